// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand request and result handshake bundle for the nibble-serial adder.
// The slave side is the sequencer, the master side is the requester/consumer.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid,
    input  in_ready,
    output in_a,
    output in_b,
    output in_sub,
    input  out_valid,
    output out_ready,
    input  out_sum,
    input  out_cout,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_a,
    input  in_b,
    input  in_sub,
    output out_valid,
    input  out_ready,
    output out_sum,
    output out_cout,
    output out_ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequenced over a single 4-bit ripple slice,
// least significant nibble first, with valid/ready on both sides.
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  always_comb begin
    logic cy;
    cy  = c_in;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    c_out = cy;
  end
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cout_q;
  logic             ovf_q;

  logic [3:0] sl_a;
  logic [3:0] sl_b;
  logic [3:0] sl_sum;
  logic       sl_cout;
  logic       last;

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        sl_a = a_q[4*i +: 4];
        sl_b = b_q[4*i +: 4];
      end
    end
  end

  assign last = (cnt_q == CW'(NIB - 1));

  ripple_carry_adder u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .c_in  (carry_q),
    .sum   (sl_sum),
    .c_out (sl_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_sub ? ~bus.in_b : bus.in_b;
            carry_q    <= bus.in_sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CW'(i)) begin
              sum_q[4*i +: 4] <= sl_sum;
            end
          end
          carry_q <= sl_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= sl_cout;
            // top nibble's sum bit 3 is the result MSB
            ovf_q       <= (a_q[WIDTH-1] == b_q[WIDTH-1])
                         & (sl_sum[3] != a_q[WIDTH-1]);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and randomized checks of the nibble-serial add/sub sequencer
// against an arithmetic reference model.
module tb_nibble_serial_add_ctrl;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // returns {cout, ovf, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic sub);
    longint ua, ub, sa, sb, r, s;
    logic   cout, ovf;
    logic [63:0] rv;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!sub) begin
      r    = ua + ub;
      s    = sa + sb;
      cout = (r >= (longint'(1) << W));
    end else begin
      r    = ua - ub;
      s    = sa - sb;
      cout = (ua >= ub);
    end
    ovf = (s > (longint'(1) << (W-1)) - 1) || (s < -(longint'(1) << (W-1)));
    rv  = r;
    return {cout, ovf, rv[W-1:0]};
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] e_sum, input logic e_cout,
                       input logic e_ovf);
    int cyc;
    cyc = 0;
    while (!bus.in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_ready"}, bus.in_ready, 1'b1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_sub = sub;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, NIB);
    chk({tag, "_sum"}, bus.out_sum, e_sum);
    chk({tag, "_cout"}, bus.out_cout, e_cout);
    chk({tag, "_ovf"}, bus.out_ovf, e_ovf);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_vdrop"}, bus.out_valid, 1'b0);
    chk({tag, "_rdy"}, bus.in_ready, 1'b1);
  endtask

  task automatic new_ops();
    bus.in_a = W'($urandom);
    bus.in_b = W'($urandom);
    bus.in_sub = 1'($urandom);
  endtask

  task automatic run_stream(input string tag, input int n_ops,
                            input bit rand_ready, input bit chk_gap);
    logic [W+1:0] exp_q[$];
    logic [W+1:0] e;
    logic [W-1:0] s_sum;
    logic         s_cout, s_ovf, s_valid, hs_in, hs_out;
    int sent, got, cyc, last_acc;
    sent = 0;
    got = 0;
    cyc = 0;
    last_acc = -1;
    new_ops();
    bus.in_valid = 1'b1;
    bus.out_ready = rand_ready ? 1'($urandom) : 1'b1;
    while (got < n_ops && cyc < n_ops * 20 + 50) begin
      hs_in   = bus.in_valid && bus.in_ready;
      hs_out  = bus.out_valid && bus.out_ready;
      s_valid = bus.out_valid;
      s_sum   = bus.out_sum;
      s_cout  = bus.out_cout;
      s_ovf   = bus.out_ovf;
      if (hs_in)
        exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_sub));
      tick();
      cyc++;
      if (hs_in) begin
        if (chk_gap && last_acc >= 0)
          chk({tag, "_gap"}, cyc - last_acc, NIB + 2);
        last_acc = cyc;
        sent++;
        if (sent < n_ops) new_ops();
        else bus.in_valid = 1'b0;
      end
      if (hs_out) begin
        got++;
        chk({tag, "_qnonempty"}, exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, "_res"}, {s_cout, s_ovf, s_sum}, e);
        end
      end else if (s_valid) begin
        chk({tag, "_hold"}, {bus.out_valid, bus.out_cout, bus.out_ovf,
                             bus.out_sum}, {1'b1, s_cout, s_ovf, s_sum});
      end
      if (rand_ready) bus.out_ready = 1'($urandom);
    end
    chk({tag, "_count"}, got, n_ops);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] h_sum;
    logic         h_cout, h_ovf;
    int           cyc;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sub = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ready", bus.in_ready, 1'b1);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_out", {bus.out_cout, bus.out_ovf, bus.out_sum}, '0);
    rst_n = 1'b1;
    tick();

    // reset during the second RUN cycle
    bus.in_a = 16'h1234;
    bus.in_b = 16'h4321;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_busy", bus.in_ready, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_valid", bus.out_valid, 1'b0);
    chk("mid_ready", bus.in_ready, 1'b1);
    chk("mid_sum", bus.out_sum, '0);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) cyc++;
    end
    chk("mid_noresult", cyc, 0);

    do_op("add_ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_brw", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // backpressure in DONE with a competing request
    bus.in_a = 16'h1111;
    bus.in_b = 16'h2222;
    bus.in_sub = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_a = 16'hAAAA;
    bus.in_b = 16'h5555;
    bus.in_sub = 1'b1;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("bp_lat", cyc, NIB);
    h_sum = bus.out_sum;
    h_cout = bus.out_cout;
    h_ovf = bus.out_ovf;
    chk("bp_sum", h_sum, 16'h3333);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {bus.out_valid, bus.in_ready, bus.out_cout,
                      bus.out_ovf, bus.out_sum},
          {1'b1, 1'b0, h_cout, h_ovf, h_sum});
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
    chk("bp_keep", bus.out_sum, h_sum);
    tick();

    run_stream("b2b", 3, 1'b0, 1'b1);
    repeat (3) tick();
    run_stream("rand", 1000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
